hkspi_flash_passthru: RTL and testbench

Pass-through engine that sits directly downstream of the housekeeping SPI slave and owns the flash-side pins during pass-through transactions. When the slave decodes a management-flash or user-flash pass-through command, this block selects one flash target. It then drives that flash's chip select and forwards host SCK and SDI glitch-free from the first bit after the command byte. It returns the flash's IO1 as pass-through SDO and counts transferred bytes, with an optional byte limit. All state is scoped to one host transaction and cleared when CSB rises.

---
 rtl/hkspi_flash_passthru.sv | 105 ++++++++++
 tb/tb_hkspi_flash_passthru.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hkspi_flash_passthru.sv
// Housekeeping SPI flash pass-through engine: selects one flash, forwards host SCK/SDI to it
// glitch-free and returns its IO1, counting transferred bytes with an optional limit.
module hkspi_flash_passthru #(
    parameter int unsigned BYTE_W     = 16,
    parameter int unsigned BYTE_LIMIT = 0
) (
    input  logic              SCK,
    input  logic              csb_reset,
    input  logic              SDI,
    input  logic              pt_mgmt_req,
    input  logic              pt_user_req,
    input  logic              mgmt_flash_io1,
    input  logic              user_flash_io1,
    output logic              mgmt_flash_csb_n,
    output logic              user_flash_csb_n,
    output logic              mgmt_flash_sck,
    output logic              user_flash_sck,
    output logic              mgmt_flash_io0,
    output logic              user_flash_io0,
    output logic              pt_sdo,
    output logic              pt_active,
    output logic              pt_target,
    output logic [BYTE_W-1:0] pt_bytes,
    output logic              pt_limit_hit
);

    typedef enum logic [1:0] {StIdle, StArmed, StActive, StDone} state_e;

    localparam logic [BYTE_W-1:0] ByteMax  = '1;
    localparam logic [BYTE_W-1:0] ByteOne  = {{(BYTE_W-1){1'b0}}, 1'b1};
    localparam logic [BYTE_W-1:0] LimitVal = BYTE_W'(BYTE_LIMIT);
    localparam bit                LimitEn  = (BYTE_LIMIT != 0);

    state_e            state_q, state_d;
    logic              target_q, target_d;
    logic              gate_q, gate_d;
    logic [2:0]        bit_cnt_q;
    logic [BYTE_W-1:0] byte_cnt_q;
    logic              active, done;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unique case (state_q)
            StIdle: begin
                if (pt_mgmt_req || pt_user_req) begin
                    state_d  = StArmed;
                    // Management wins when both requests are high.
                    target_d = ~pt_mgmt_req;
                end
            end
            StArmed:  state_d = StActive;
            StActive: begin
                if (LimitEn && (byte_cnt_q == LimitVal)) begin
                    state_d = StDone;
                end
            end
            StDone:   state_d = StDone;
            default:  state_d = StIdle;
        endcase
        gate_d = (state_d == StActive);
    end

    // Falling-edge state keeps the gate stable for the whole SCK high phase.
    always_ff @(negedge SCK or posedge csb_reset) begin
        if (csb_reset) begin
            state_q  <= StIdle;
            target_q <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            gate_q   <= gate_d;
        end
    end

    always_ff @(posedge SCK or posedge csb_reset) begin
        if (csb_reset) begin
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
        end else if (gate_q) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if ((bit_cnt_q == 3'd7) && (byte_cnt_q != ByteMax)) begin
                byte_cnt_q <= byte_cnt_q + ByteOne;
            end
        end
    end

    always_comb begin
        active           = (state_q == StActive);
        done             = (state_q == StDone);
        mgmt_flash_csb_n = ~(active & ~target_q);
        user_flash_csb_n = ~(active & target_q);
        mgmt_flash_sck   = SCK & gate_q & ~target_q;
        user_flash_sck   = SCK & gate_q & target_q;
        mgmt_flash_io0   = active & ~target_q & SDI;
        user_flash_io0   = active & target_q & SDI;
        pt_sdo           = active & (target_q ? user_flash_io1 : mgmt_flash_io1);
        pt_active        = active | done;
        pt_target        = target_q;
        pt_bytes         = byte_cnt_q;
        pt_limit_hit     = done;
    end

endmodule

// File: tb/tb_hkspi_flash_passthru.sv
// Bench for hkspi_flash_passthru: three parameterisations driven by one host stream, checked
// against a transaction-level model of rise/fall counts.
module tb_hkspi_flash_passthru;

    logic sck, csb_reset, sdi, mreq, ureq, mio1, uio1;
    logic m_csb [3];
    logic u_csb [3];
    logic m_sck [3];
    logic u_sck [3];
    logic m_io0 [3];
    logic u_io0 [3];
    logic sdo   [3];
    logic act   [3];
    logic tgt   [3];
    logic hit   [3];
    logic [15:0] by0, by1;
    logic [3:0]  by2;

    hkspi_flash_passthru dut0 (
        .SCK(sck), .csb_reset(csb_reset), .SDI(sdi), .pt_mgmt_req(mreq), .pt_user_req(ureq),
        .mgmt_flash_io1(mio1), .user_flash_io1(uio1),
        .mgmt_flash_csb_n(m_csb[0]), .user_flash_csb_n(u_csb[0]),
        .mgmt_flash_sck(m_sck[0]), .user_flash_sck(u_sck[0]),
        .mgmt_flash_io0(m_io0[0]), .user_flash_io0(u_io0[0]),
        .pt_sdo(sdo[0]), .pt_active(act[0]), .pt_target(tgt[0]), .pt_bytes(by0),
        .pt_limit_hit(hit[0])
    );

    hkspi_flash_passthru #(.BYTE_W(16), .BYTE_LIMIT(2)) dut1 (
        .SCK(sck), .csb_reset(csb_reset), .SDI(sdi), .pt_mgmt_req(mreq), .pt_user_req(ureq),
        .mgmt_flash_io1(mio1), .user_flash_io1(uio1),
        .mgmt_flash_csb_n(m_csb[1]), .user_flash_csb_n(u_csb[1]),
        .mgmt_flash_sck(m_sck[1]), .user_flash_sck(u_sck[1]),
        .mgmt_flash_io0(m_io0[1]), .user_flash_io0(u_io0[1]),
        .pt_sdo(sdo[1]), .pt_active(act[1]), .pt_target(tgt[1]), .pt_bytes(by1),
        .pt_limit_hit(hit[1])
    );

    hkspi_flash_passthru #(.BYTE_W(4), .BYTE_LIMIT(0)) dut2 (
        .SCK(sck), .csb_reset(csb_reset), .SDI(sdi), .pt_mgmt_req(mreq), .pt_user_req(ureq),
        .mgmt_flash_io1(mio1), .user_flash_io1(uio1),
        .mgmt_flash_csb_n(m_csb[2]), .user_flash_csb_n(u_csb[2]),
        .mgmt_flash_sck(m_sck[2]), .user_flash_sck(u_sck[2]),
        .mgmt_flash_io0(m_io0[2]), .user_flash_io0(u_io0[2]),
        .pt_sdo(sdo[2]), .pt_active(act[2]), .pt_target(tgt[2]), .pt_bytes(by2),
        .pt_limit_hit(hit[2])
    );

    int n_tests, n_fail;
    // Model of the host transaction: rises seen, SCK level, request kind, reset.
    int m_r, m_kind;
    bit m_hi, m_rst;
    event smp_ev;

    // Flash clock edge counters (edge-based, so runt pulses would show up).
    int cm0 = 0, cm1 = 0, cm2 = 0, cu0 = 0, cu1 = 0, cu2 = 0, ffc = 0;
    int pb_m [3];
    int pb_u [3];
    int ffc_base;
    logic [31:0] io0_cap;
    logic [23:0] id_cap;

    always @(posedge m_sck[0]) cm0++;
    always @(posedge m_sck[1]) cm1++;
    always @(posedge m_sck[2]) cm2++;
    always @(posedge u_sck[0]) cu0++;
    always @(posedge u_sck[1]) cu1++;
    always @(posedge u_sck[2]) cu2++;
    always @(negedge m_sck[0]) ffc++;
    always @(posedge m_sck[0]) io0_cap = {io0_cap[30:0], m_io0[0]};

    function automatic int cnt_m(input int i);
        return (i == 0) ? cm0 : (i == 1) ? cm1 : cm2;
    endfunction

    function automatic int cnt_u(input int i);
        return (i == 0) ? cu0 : (i == 1) ? cu1 : cu2;
    endfunction

    function automatic logic [31:0] bytes_of(input int i);
        return (i == 0) ? {16'd0, by0} : (i == 1) ? {16'd0, by1} : {28'd0, by2};
    endfunction

    function automatic int lim_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic int max_of(input int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    // Flash rises forwarded so far: every host rise after the 8th, capped by the limit.
    function automatic int exp_fr(input int i);
        int fr;
        fr = (m_kind != 0 && m_r > 8) ? m_r - 8 : 0;
        if (lim_of(i) != 0 && fr > 8 * lim_of(i)) fr = 8 * lim_of(i);
        return fr;
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s[%0d] t=%0t got %0h want %0h", nm, idx, $time, got, exp);
        end
    endtask

    task automatic chk_inst(input int i);
        int f, fr, eb, lim;
        bit eng, done, actv, tsel;
        lim  = lim_of(i);
        f    = m_rst ? -1 : (m_hi ? m_r - 1 : m_r);
        fr   = m_rst ? 0 : exp_fr(i);
        eb   = fr / 8;
        if (eb > max_of(i)) eb = max_of(i);
        eng  = (m_kind != 0) && (f >= 8);
        done = eng && (lim != 0) && (f >= 8 + 8 * lim);
        actv = eng && !done;
        tsel = (m_kind == 2) && (f >= 7);
        cmp("mgmt_csb_n", i, m_csb[i], !(actv && !tsel));
        cmp("user_csb_n", i, u_csb[i], !(actv && tsel));
        cmp("mgmt_sck",   i, m_sck[i], actv && !tsel && m_hi);
        cmp("user_sck",   i, u_sck[i], actv && tsel && m_hi);
        cmp("mgmt_io0",   i, m_io0[i], actv && !tsel && sdi);
        cmp("user_io0",   i, u_io0[i], actv && tsel && sdi);
        cmp("pt_sdo",     i, sdo[i],   actv && (tsel ? uio1 : mio1));
        cmp("pt_active",  i, act[i],   eng);
        cmp("pt_target",  i, tgt[i],   tsel);
        cmp("pt_limit",   i, hit[i],   done);
        cmp("pt_bytes",   i, bytes_of(i), eb);
    endtask

    always @(smp_ev) begin
        for (int i = 0; i < 3; i++) chk_inst(i);
    end

    task automatic sample();
        -> smp_ev;
        #1;
    endtask

    task automatic check_pulses();
        bit selm;
        selm = (m_kind == 1 || m_kind == 3);
        for (int i = 0; i < 3; i++) begin
            cmp("pulses_mgmt", i, cnt_m(i) - pb_m[i], selm ? exp_fr(i) : 0);
            cmp("pulses_user", i, cnt_u(i) - pb_u[i], (m_kind == 2) ? exp_fr(i) : 0);
        end
    endtask

    task automatic run_txn(input int kind, input logic [7:0] cmd, input int nbytes,
                           input int abort_r, input bit jedec);
        logic [7:0]  b;
        logic [23:0] jid;
        int          total, fc;
        jid = 24'hEF4018;
        for (int i = 0; i < 3; i++) begin
            pb_m[i] = cnt_m(i);
            pb_u[i] = cnt_u(i);
        end
        ffc_base  = ffc;
        b         = cmd;
        csb_reset = 0;
        m_rst     = 0;
        m_r       = 0;
        m_hi      = 0;
        m_kind    = kind;
        #5 sample();
        total = 8 * (nbytes + 1);
        for (int k = 0; k < total; k++) begin
            if (k % 8 == 0)
                b = (k == 0) ? cmd : (jedec && k == 8) ? 8'h9F : 8'($urandom);
            sdi = b[7 - (k % 8)];
            fc  = ffc - ffc_base;
            mio1 = (jedec && fc >= 8 && fc <= 31) ? jid[23 - (fc - 8)] : 1'($urandom);
            uio1 = 1'($urandom);
            #4 sample();
            #4;
            sck  = 1;
            m_r  = m_r + 1;
            m_hi = 1;
            #1;
            if (m_r == 7) begin
                mreq = (kind == 1 || kind == 3);
                ureq = (kind == 2 || kind == 3);
            end
            #2 sample();
            if (jedec && m_r >= 17 && m_r <= 40) id_cap = {id_cap[22:0], sdo[0]};
            if (abort_r == m_r) begin
                csb_reset = 1;
                m_rst     = 1;
                mreq      = 0;
                ureq      = 0;
                #1 sample();
                #4 sck = 0;
                m_hi = 0;
                #5 sample();
                return;
            end
            #4;
            sck  = 0;
            m_hi = 0;
            #1;
        end
        sdi = 0;
        #2 sample();
    endtask

    task automatic end_txn();
        csb_reset = 1;
        m_rst     = 1;
        mreq      = 0;
        ureq      = 0;
        #1 sample();
        check_pulses();
        #20;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout t=%0t got no finish want finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int kind, nb, ab;
        logic [7:0] cmd;
        n_tests = 0; n_fail = 0;
        sck = 0; sdi = 0; mreq = 0; ureq = 0; mio1 = 0; uio1 = 0; csb_reset = 0;
        m_rst = 1; m_r = 0; m_hi = 0; m_kind = 0;
        #1 csb_reset = 1;
        #4 sample();
        cmp("rst_mgmt_csb_n", 0, m_csb[0], 1'b1);
        cmp("rst_active", 0, act[0], 1'b0);

        // Management JEDEC read: 0x9F then 3 dummy bytes.
        run_txn(1, 8'hC4, 4, 0, 1);
        cmp("jedec_bytes", 0, bytes_of(0), 32'd4);
        cmp("jedec_pulses", 0, cnt_m(0) - pb_m[0], 32'd32);
        cmp("jedec_io0_cmd", 0, {24'd0, io0_cap[31:24]}, 32'h9F);
        cmp("jedec_id", 0, {8'd0, id_cap}, 32'hEF4018);
        cmp("jedec_user_idle", 0, cnt_u(0) - pb_u[0], 32'd0);
        end_txn();

        run_txn(2, 8'hC2, 3, 0, 0);
        cmp("user_target", 0, tgt[0], 1'b1);
        cmp("user_pulses", 0, cnt_u(0) - pb_u[0], 32'd24);
        end_txn();

        run_txn(3, 8'hC4, 2, 0, 0);
        cmp("both_target", 0, tgt[0], 1'b0);
        end_txn();

        // Limit of 2 on dut1 while the host clocks 5 bytes.
        run_txn(1, 8'hC4, 5, 0, 0);
        cmp("limit_pulses", 1, cnt_m(1) - pb_m[1], 32'd16);
        cmp("limit_hit", 1, hit[1], 1'b1);
        cmp("limit_bytes", 1, bytes_of(1), 32'd2);
        cmp("limit_sdo", 1, sdo[1], 1'b0);
        cmp("limit_csb_n", 1, m_csb[1], 1'b1);
        end_txn();

        // Abort after 3 bits of flash byte 1, then a normal transaction.
        run_txn(1, 8'hC4, 5, 19, 0);
        cmp("abort_csb_n", 0, m_csb[0], 1'b1);
        cmp("abort_pulses", 0, cnt_m(0) - pb_m[0], 32'd11);
        end_txn();
        run_txn(1, 8'hC4, 1, 0, 0);
        cmp("reengage_bytes", 0, bytes_of(0), 32'd1);
        end_txn();

        run_txn(0, 8'h80, 4, 0, 0);
        cmp("nopt_pulses", 0, cnt_m(0) - pb_m[0], 32'd0);
        end_txn();

        // Saturation on the 4-bit counter.
        run_txn(1, 8'hC4, 20, 0, 0);
        cmp("sat_bytes", 2, bytes_of(2), 32'd15);
        cmp("sat_pulses", 2, cnt_m(2) - pb_m[2], 32'd160);
        cmp("sat_wide_bytes", 0, bytes_of(0), 32'd20);
        end_txn();

        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 3);
            nb   = $urandom_range(0, 20);
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8 * (nb + 1)) : 0;
            cmd  = (kind == 0) ? 8'h03 : (kind == 2) ? 8'hC2 : 8'hC4;
            run_txn(kind, cmd, nb, ab, 0);
            end_txn();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
